axis_sync_fifo: RTL



---
 rtl/axis_pkg.sv | 24 ++
 rtl/axis_fifo_mem.sv | 26 ++
 rtl/axis_sync_fifo.sv | 125 ++++++++++++
 3 files changed

// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream FIFO.
// Word layout is {last, data}.
package axis_pkg;

  localparam int AXIS_DEFAULT_DATA_W = 32;

  typedef struct packed {
    logic                           last;
    logic [AXIS_DEFAULT_DATA_W-1:0] data;
  } axis_word_t;

  function automatic int clog2_f(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// Storage array for axis_sync_fifo.
// Synchronous write, asynchronous read.
module axis_fifo_mem
  import axis_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 33,
  localparam int AW   = clog2_f(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axis_sync_fifo.sv
// Single-clock AXI-Stream FIFO, first-word-fall-through.
// Define AXIS_FIFO_PACKET_MODE_EN for store-and-forward.
module axis_sync_fifo
  import axis_pkg::*;
#(
  parameter int DATA_W  = AXIS_DEFAULT_DATA_W,
  parameter int DEPTH   = 16,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              s_axis_clk,
  input  logic              s_axis_resetn,
  input  logic              s_axis_valid,
  input  logic              s_axis_last,
  input  logic [DATA_W-1:0] s_axis_data,
  output logic              s_axis_ready,
  output logic              m_axis_valid,
  output logic              m_axis_last,
  output logic [DATA_W-1:0] m_axis_data,
  input  logic              m_axis_ready,
  output logic [CNT_W-1:0]  level
`ifdef AXIS_FIFO_PACKET_MODE_EN
  ,
  output logic              oversize
`endif
);

  localparam int AW = clog2_f(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CNT_W-1:0] r_level;
  logic [CNT_W-1:0] w_level_nxt;
  logic             r_ready;
  logic             w_wr;
  logic             w_rd;
  logic             w_valid;
  logic [DATA_W:0]  w_rdata;

  assign w_wr = s_axis_valid & r_ready;
  assign w_rd = w_valid & m_axis_ready;

  always_comb begin
    w_level_nxt = r_level;
    unique case ({w_wr, w_rd})
      2'b10:   w_level_nxt = r_level + CNT_W'(1);
      2'b01:   w_level_nxt = r_level - CNT_W'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Ready comes from the next level, so a read never frees a same-cycle write.
  always_ff @(posedge s_axis_clk) begin
    if (!s_axis_resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ready <= 1'b1;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      r_level <= w_level_nxt;
      r_ready <= (w_level_nxt != FULL);
    end
  end

  axis_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_mem (
    .i_clk   (s_axis_clk),
    .i_we    (w_wr),
    .i_waddr (r_wptr),
    .i_wdata ({s_axis_last, s_axis_data}),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

`ifdef AXIS_FIFO_PACKET_MODE_EN
  logic [CNT_W-1:0] r_pkts;
  logic             r_cut;
  logic             r_oversize;
  logic             w_stuck;
  logic             w_inc;
  logic             w_dec;

  // Full with no complete packet: open the gate so the FIFO cannot lock up.
  assign w_stuck = (r_level == FULL) && (r_pkts == '0);
  assign w_inc   = w_wr & s_axis_last;
  assign w_dec   = w_rd & w_rdata[DATA_W];
  assign w_valid = (r_level != '0) &&
                   ((r_pkts != '0) || r_cut || w_stuck);

  always_ff @(posedge s_axis_clk) begin
    if (!s_axis_resetn) begin
      r_pkts     <= '0;
      r_cut      <= 1'b0;
      r_oversize <= 1'b0;
    end else begin
      unique case ({w_inc, w_dec})
        2'b10:   r_pkts <= r_pkts + CNT_W'(1);
        2'b01:   r_pkts <= r_pkts - CNT_W'(1);
        default: r_pkts <= r_pkts;
      endcase
      if (w_stuck) begin
        r_cut      <= 1'b1;
        r_oversize <= 1'b1;
      end else if (w_dec) begin
        r_cut <= 1'b0;
      end
    end
  end

  assign oversize = r_oversize;
`else
  assign w_valid = (r_level != '0);
`endif

  assign s_axis_ready = r_ready;
  assign m_axis_valid = w_valid;
  assign m_axis_last  = w_valid & w_rdata[DATA_W];
  assign m_axis_data  = w_valid ? w_rdata[DATA_W-1:0] : '0;
  assign level        = r_level;

endmodule
